// File: rtl/wimax_interleaver.sv
// WiMAX QPSK bit interleaver: serial in, 802.16 block permutation, serial out.
// Ping-pong banks let a new block be written while the previous one is read out.
module wimax_interleaver #(
    parameter int NCBPS = 192,
    parameter int NCPC  = 2,
    parameter int D     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic data_in,
    input  logic valid_in,
    output logic data_out,
    output logic valid_out,
    output logic block_start
);
    localparam int ROWS = NCBPS / D;
    localparam int AW   = $clog2(NCBPS);
    localparam int CW   = $clog2(D);
    localparam int RW   = $clog2(ROWS);

    localparam logic [AW-1:0] ADDR_LAST = AW'(NCBPS - 1);
    localparam logic [AW-1:0] ROW_STEP  = AW'(ROWS);
    localparam logic [CW-1:0] COL_LAST  = CW'(D - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

    if (NCPC != 2) begin : g_ncpc_unsupported
        $error("wimax_interleaver supports NCPC=2 (QPSK) only");
    end

    typedef enum logic {IDLE, READ} state_t;

    logic [NCBPS-1:0] bank [2];

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [AW-1:0] m;
    logic          wr_sel;
    logic          wr_last;
    logic [1:0]    full;
    logic          clr_full;

    state_t        state, nxt_state;
    logic [AW-1:0] rd_addr, nxt_addr;
    logic          rd_sel, nxt_sel;

    assign wr_last = valid_in && (col == COL_LAST) && (row == ROW_LAST);

    // m tracks 12*col + row incrementally so no multiplier is needed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col    <= '0;
            row    <= '0;
            m      <= '0;
            wr_sel <= 1'b0;
        end else if (valid_in) begin
            if (col == COL_LAST) begin
                col <= '0;
                if (row == ROW_LAST) begin
                    row    <= '0;
                    m      <= '0;
                    wr_sel <= ~wr_sel;
                end else begin
                    row <= row + 1'b1;
                    m   <= AW'(row) + AW'(1);
                end
            end else begin
                col <= col + 1'b1;
                m   <= m + ROW_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            bank[wr_sel][m] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= '0;
        end else begin
            if (clr_full) full[rd_sel] <= 1'b0;
            if (wr_last)  full[wr_sel] <= 1'b1;
        end
    end

    // The full flag drops as the last address is emitted, so the writer may
    // refill that bank on the very next edge.
    always_comb begin
        nxt_state = state;
        nxt_addr  = rd_addr;
        nxt_sel   = rd_sel;
        clr_full  = 1'b0;
        unique case (state)
            IDLE: begin
                if (full[rd_sel]) begin
                    nxt_state = READ;
                    nxt_addr  = '0;
                end else if (full[~rd_sel]) begin
                    nxt_state = READ;
                    nxt_addr  = '0;
                    nxt_sel   = ~rd_sel;
                end
            end
            READ: begin
                if (rd_addr == ADDR_LAST) begin
                    nxt_sel   = ~rd_sel;
                    nxt_addr  = '0;
                    nxt_state = full[~rd_sel] ? READ : IDLE;
                end else begin
                    nxt_addr = rd_addr + 1'b1;
                    clr_full = (nxt_addr == ADDR_LAST);
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rd_addr     <= '0;
            rd_sel      <= 1'b0;
            data_out    <= 1'b0;
            valid_out   <= 1'b0;
            block_start <= 1'b0;
        end else begin
            state       <= nxt_state;
            rd_addr     <= nxt_addr;
            rd_sel      <= nxt_sel;
            valid_out   <= (nxt_state == READ);
            block_start <= (nxt_state == READ) && (nxt_addr == '0);
            data_out    <= (nxt_state == READ) && bank[nxt_sel][nxt_addr];
        end
    end

    a_no_overwrite: assert property (@(posedge clk) disable iff (reset)
        !(valid_in && full[wr_sel]));

endmodule

// File: tb/tb_wimax_interleaver.sv
// Self-checking bench for wimax_interleaver: per-cycle comparison against a
// behavioural permutation/timing model, plus literal reference vectors.
module tb_wimax_interleaver;
    localparam logic [191:0] REF_IN  = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;
    localparam logic [191:0] REF_OUT = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic data_in = 1'b0;
    logic valid_in = 1'b0;
    logic data_out, valid_out, block_start;

    wimax_interleaver #(.NCBPS(192), .NCPC(2), .D(16)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out), .valid_out(valid_out), .block_start(block_start)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint       e;
        logic [191:0] bits;
    } blk_t;

    blk_t         exp_q[$];
    blk_t         cur;
    bit           active = 1'b0;
    longint       cur_start = 0;
    longint       last_end = -1000;
    longint       st;
    logic [191:0] got_vec = '0;
    logic [191:0] got_q[$];
    int           run = 0;
    int           last_run = 0;
    int           idx;
    logic [2:0]   exp3;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Input bit k lands at output position 12*(k mod 16) + k/16; vectors are MSB-first.
    function automatic logic [191:0] permute(input logic [191:0] v);
        logic [191:0] o;
        o = '0;
        for (int k = 0; k < 192; k++) o[191 - (12 * (k % 16) + k / 16)] = v[191 - k];
        return o;
    endfunction

    function automatic logic [191:0] next_got();
        if (got_q.size() == 0) return 'x;
        return got_q.pop_front();
    endfunction

    // Timing model: a block completed at edge E starts output at max(E+1, previous end+1).
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            active   = 1'b0;
            last_end = -1000;
            run      = 0;
            check("reset_outputs", {valid_out, block_start, data_out}, 3'b000);
        end else begin
            if (!active && exp_q.size() > 0) begin
                st = (exp_q[0].e + 1 > last_end + 1) ? exp_q[0].e + 1 : last_end + 1;
                if (cyc >= st) begin
                    cur       = exp_q.pop_front();
                    active    = 1'b1;
                    cur_start = st;
                end
            end
            exp3 = 3'b000;
            if (active) begin
                idx     = int'(cyc - cur_start);
                exp3    = {1'b1, idx == 0, cur.bits[191 - idx]};
                got_vec = {got_vec[190:0], data_out};
                if (idx == 191) begin
                    active   = 1'b0;
                    last_end = cyc;
                    got_q.push_back(got_vec);
                end
            end
            check("cycle_out", {valid_out, block_start, data_out}, exp3);
            if (valid_out) begin
                run++;
            end else begin
                if (run > 0) last_run = run;
                run = 0;
            end
        end
    end

    // gap_mode: 0 continuous, 1 one idle cycle after every bit, 2 random idle cycles
    task automatic send_block(input logic [191:0] v, input int gap_mode, input int nbits);
        blk_t b;
        int   gaps;
        for (int k = 0; k < nbits; k++) begin
            data_in  = v[191 - k];
            valid_in = 1'b1;
            @(posedge clk);
            #1;
            if (k == 191) begin
                b.e    = cyc;
                b.bits = permute(v);
                exp_q.push_back(b);
            end
            gaps = 0;
            if (gap_mode == 1) gaps = 1;
            else if (gap_mode == 2 && $urandom_range(0, 3) == 0) gaps = int'($urandom_range(1, 2));
            for (int g = 0; g < gaps; g++) begin
                valid_in = 1'b0;
                data_in  = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (!active && exp_q.size() == 0) break;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [191:0] g;
        logic [191:0] v;
        logic [191:0] rv[6];

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", valid_out, 1'b0);
        reset = 1'b0;

        check("model_ref", permute(REF_IN), REF_OUT);
        check("model_bit17", permute(192'b1 << 174), 192'b1 << 178);

        // Reference block
        got_q.delete();
        send_block(REF_IN, 0, 192);
        valid_in = 1'b0;
        drain();
        g = next_got();
        check("ref_block", g, REF_OUT);
        check("ref_first4", g[191:188], 4'b0100);
        check("ref_run_len", last_run, 192);

        // Back-to-back: reference, all ones, reference
        got_q.delete();
        send_block(REF_IN, 0, 192);
        send_block('1, 0, 192);
        send_block(REF_IN, 0, 192);
        valid_in = 1'b0;
        drain();
        check("b2b_blk0", next_got(), REF_OUT);
        check("b2b_blk1", next_got(), {192{1'b1}});
        check("b2b_blk2", next_got(), REF_OUT);
        check("b2b_run_len", last_run, 576);

        // Alternating valid_in
        got_q.delete();
        send_block(REF_IN, 1, 192);
        valid_in = 1'b0;
        drain();
        check("gapped_block", next_got(), REF_OUT);
        check("gapped_run_len", last_run, 192);

        // Single set bit k=17 must emerge at output index 13
        got_q.delete();
        v = 192'b1 << 174;
        send_block(v, 0, 192);
        valid_in = 1'b0;
        drain();
        check("single_bit17", next_got(), 192'b1 << 178);

        // Reset after 100 input bits
        got_q.delete();
        send_block(REF_IN, 0, 100);
        reset = 1'b1;
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        send_block(REF_IN, 0, 192);
        valid_in = 1'b0;
        drain();
        check("after_partial_reset", next_got(), REF_OUT);

        // Reset 50 cycles into a read
        got_q.delete();
        send_block(REF_IN, 0, 192);
        valid_in = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("pre_reset_valid", valid_out, 1'b1);
        reset = 1'b1;
        #1;
        check("reset_drop_valid", valid_out, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_no_leftover", got_q.size(), 0);
        send_block(REF_IN, 0, 192);
        valid_in = 1'b0;
        drain();
        check("after_read_reset", next_got(), REF_OUT);

        // Random blocks, random gaps, sometimes back-to-back
        got_q.delete();
        for (int b = 0; b < 6; b++) begin
            rv[b] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send_block(rv[b], 2, 192);
            if ($urandom_range(0, 1) == 1) begin
                valid_in = 1'b0;
                repeat ($urandom_range(1, 40)) @(posedge clk);
                #1;
            end
        end
        valid_in = 1'b0;
        drain();
        for (int b = 0; b < 6; b++) check("random_block", next_got(), permute(rv[b]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
